// File: rtl/pmem_arbiter.sv
// pmem_arbiter: round-robin arbiter that multiplexes NUM_PORTS cache-side line
// requests onto a single physical-memory port, one transaction at a time.
//
// Optional feature macro: PMEM_ARB_PERF_CNT_EN
//   defined   -> grant_cnt / stall_cnt are saturating performance counters
//   undefined -> grant_cnt / stall_cnt are tied to 0 and no counter flops exist
//
// Parameters
//   NUM_PORTS  number of cache ports (2..8); port 0 = I-cache, port 1 = D-cache
//   LINE_W     cacheline width in bits
//   ADDR_W     address width in bits
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   c_read/c_write per-port line read / write requests
//   c_address      per-port address, port i at [i*ADDR_W +: ADDR_W]
//   c_wdata        per-port write line, port i at [i*LINE_W +: LINE_W]
//   c_rdata        read line broadcast to all ports (wire copy of pmem_rdata)
//   c_resp         per-port one-cycle completion pulse
//   pmem_*         memory-side command, address, write line, read line, response
//   grant_cnt      per-port completed-transaction counters, port i at [i*32 +: 32]
//   stall_cnt      busy cycles in which a non-granted port was waiting
module pmem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int LINE_W    = 256,
  parameter int ADDR_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_PORTS-1:0]      c_read,
  input  logic [NUM_PORTS-1:0]      c_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] c_address,
  input  logic [NUM_PORTS*LINE_W-1:0] c_wdata,
  output logic [LINE_W-1:0]         c_rdata,
  output logic [NUM_PORTS-1:0]      c_resp,
  output logic                      pmem_read,
  output logic                      pmem_write,
  output logic [ADDR_W-1:0]         pmem_address,
  output logic [LINE_W-1:0]         pmem_wdata,
  input  logic [LINE_W-1:0]         pmem_rdata,
  input  logic                      pmem_resp,
  output logic [NUM_PORTS*32-1:0]   grant_cnt,
  output logic [31:0]               stall_cnt
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {StIdle, StBusy} state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   grant;
  logic [NUM_PORTS-1:0] pending;
  logic [NUM_PORTS-1:0] grant_oh;
  logic [IDX_W-1:0]   sel;
  logic [IDX_W-1:0]   cand;
  logic               any_pending;
  logic               done;

  assign pending = c_read | c_write;
  assign done    = (state == StBusy) && pmem_resp;

  // Round-robin search: first pending port at or after ptr, wrapping.
  always_comb begin
    sel         = '0;
    cand        = '0;
    any_pending = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_PORTS);
      if (!any_pending && pending[cand]) begin
        any_pending = 1'b1;
        sel         = cand;
      end
    end
  end

  always_comb begin
    grant_oh        = '0;
    grant_oh[grant] = 1'b1;
  end

  // Completion is reported straight from pmem_resp; in IDLE it is dropped.
  assign c_resp  = done ? grant_oh : '0;
  assign c_rdata = pmem_rdata;

  // The pmem_* output flops double as the latched op/address/wdata; they are
  // cleared on completion so the memory side sees zeros whenever IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      ptr          <= '0;
      grant        <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (any_pending) begin
            state        <= StBusy;
            grant        <= sel;
            // Read+write together resolves to a write.
            pmem_write   <= c_write[sel];
            pmem_read    <= ~c_write[sel];
            pmem_address <= c_address[sel*ADDR_W +: ADDR_W];
            pmem_wdata   <= c_wdata[sel*LINE_W +: LINE_W];
          end
        end
        StBusy: begin
          if (pmem_resp) begin
            state        <= StIdle;
            ptr          <= (grant == IDX_W'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef PMEM_ARB_PERF_CNT_EN
  logic [31:0] grant_cnt_q [NUM_PORTS];
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) grant_cnt_q[i] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (c_resp[i] && (grant_cnt_q[i] != 32'hFFFF_FFFF)) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
        end
      end
      if ((state == StBusy) && |(pending & ~grant_oh) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt_out
    assign grant_cnt[g*32 +: 32] = grant_cnt_q[g];
  end
  assign stall_cnt = stall_cnt_q;
`else
  assign grant_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
module tb_pmem_arbiter;

  localparam logic [255:0] RD_LINE = {32{8'hA5}};
  localparam logic [255:0] W1      = {8{32'h1111_2222}};
  localparam logic [255:0] W2      = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] W3      = {8{32'h0BAD_F00D}};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- 2-port instance (default parameters) ----------------
  logic [1:0]   c_read2 = '0, c_write2 = '0, c_resp2;
  logic [63:0]  c_address2 = '0;
  logic [511:0] c_wdata2 = '0;
  logic [255:0] c_rdata2, pmem_wdata2;
  logic [255:0] pmem_rdata2 = RD_LINE;
  logic         pmem_read2, pmem_write2;
  logic [31:0]  pmem_address2;
  logic         resp_a2 = 1'b0, force_resp2 = 1'b0, auto2 = 1'b1;
  logic         pmem_resp2;
  logic [63:0]  grant_cnt2;
  logic [31:0]  stall_cnt2;
  int           cnt2 = 0;
  int           lat2 = 3;

  assign pmem_resp2 = resp_a2 | force_resp2;

  pmem_arbiter u_dut2 (
    .clk(clk), .rst(rst),
    .c_read(c_read2), .c_write(c_write2), .c_address(c_address2), .c_wdata(c_wdata2),
    .c_rdata(c_rdata2), .c_resp(c_resp2),
    .pmem_read(pmem_read2), .pmem_write(pmem_write2), .pmem_address(pmem_address2),
    .pmem_wdata(pmem_wdata2), .pmem_rdata(pmem_rdata2), .pmem_resp(pmem_resp2),
    .grant_cnt(grant_cnt2), .stall_cnt(stall_cnt2)
  );

  // ---------------- 4-port instance ----------------
  logic [3:0]   c_read4 = '0, c_write4 = '0, c_resp4;
  logic [63:0]  c_address4 = '0;
  logic [127:0] c_wdata4 = '0;
  logic [31:0]  c_rdata4, pmem_wdata4;
  logic [31:0]  pmem_rdata4 = 32'h1234_5678;
  logic         pmem_read4, pmem_write4;
  logic [15:0]  pmem_address4;
  logic         resp_a4 = 1'b0;
  logic [127:0] grant_cnt4;
  logic [31:0]  stall_cnt4;
  int           cnt4 = 0;
  int           lat4 = 1;

  pmem_arbiter #(.NUM_PORTS(4), .LINE_W(32), .ADDR_W(16)) u_dut4 (
    .clk(clk), .rst(rst),
    .c_read(c_read4), .c_write(c_write4), .c_address(c_address4), .c_wdata(c_wdata4),
    .c_rdata(c_rdata4), .c_resp(c_resp4),
    .pmem_read(pmem_read4), .pmem_write(pmem_write4), .pmem_address(pmem_address4),
    .pmem_wdata(pmem_wdata4), .pmem_rdata(pmem_rdata4), .pmem_resp(resp_a4),
    .grant_cnt(grant_cnt4), .stall_cnt(stall_cnt4)
  );

  // Memory models: pulse resp in the lat-th cycle a command is visible.
  always @(negedge clk) begin
    if (auto2 && !resp_a2 && (pmem_read2 || pmem_write2)) begin
      if (cnt2 + 1 == lat2) begin
        resp_a2 <= 1'b1;
        cnt2    <= 0;
      end else begin
        cnt2 <= cnt2 + 1;
      end
    end else begin
      resp_a2 <= 1'b0;
      cnt2    <= 0;
    end
  end

  always @(negedge clk) begin
    if (!resp_a4 && (pmem_read4 || pmem_write4)) begin
      if (cnt4 + 1 == lat4) begin
        resp_a4 <= 1'b1;
        cnt4    <= 0;
      end else begin
        cnt4 <= cnt4 + 1;
      end
    end else begin
      resp_a4 <= 1'b0;
      cnt4    <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sample point: just after the falling edge, well away from the rising edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_resp2(output logic [1:0] r);
    r = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (c_resp2 != '0) begin
        r = c_resp2;
        break;
      end
    end
  endtask

  task automatic wait_resp4(output logic [3:0] r);
    r = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (c_resp4 != '0) begin
        r = c_resp4;
        break;
      end
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [1:0]  r2;
  logic [3:0]  r4;
  logic [31:0] exp_g0, exp_g1, exp_st;

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #1;
    check_eq("rst_pmem_read", pmem_read2, 0);
    check_eq("rst_pmem_write", pmem_write2, 0);
    check_eq("rst_pmem_addr", pmem_address2, 0);
    check_eq("rst_c_resp", c_resp2, 0);
    check_eq("rst_grant_cnt", grant_cnt2, 0);
    check_eq("rst_stall_cnt", stall_cnt2, 0);
    tick();
    rst = 1'b0;
    tick();

    // Single read from port 0
    c_address2[31:0] = 32'h0000_1000;
    c_read2 = 2'b01;
    tick();
    c_read2 = 2'b00;
    check_eq("rd_c1_read", pmem_read2, 1);
    check_eq("rd_c1_write", pmem_write2, 0);
    check_eq("rd_c1_addr", pmem_address2, 32'h1000);
    check_eq("rd_c1_resp", c_resp2, 0);
    tick();
    check_eq("rd_c2_read", pmem_read2, 1);
    check_eq("rd_c2_resp", c_resp2, 0);
    tick();
    check_eq("rd_c3_read", pmem_read2, 1);
    check_eq("rd_c3_resp", c_resp2, 2'b01);
    check_eq("rd_c3_rdata", c_rdata2, RD_LINE);
    tick();
    check_eq("rd_idle_read", pmem_read2, 0);
    check_eq("rd_idle_addr", pmem_address2, 0);
    check_eq("rd_idle_resp", c_resp2, 0);

    // Contention from reset: 0,1,0,1 with both held high
    pulse_rst();
    c_address2 = {32'h0000_2200, 32'h0000_1100};
    c_read2 = 2'b11;
    wait_resp2(r2); check_eq("rr_g0", r2, 2'b01); tick();
    check_eq("rr_gap_read", pmem_read2, 0);
    wait_resp2(r2); check_eq("rr_g1", r2, 2'b10); tick();
    wait_resp2(r2); check_eq("rr_g2", r2, 2'b01); tick();
    wait_resp2(r2); check_eq("rr_g3", r2, 2'b10); tick();
    c_read2 = 2'b00;

    // Port 1 write; inputs change during BUSY
    c_address2[63:32] = 32'h8000_0020;
    c_wdata2[511:256] = W1;
    c_write2 = 2'b10;
    tick();
    check_eq("wr_c1_write", pmem_write2, 1);
    check_eq("wr_c1_read", pmem_read2, 0);
    check_eq("wr_c1_addr", pmem_address2, 32'h8000_0020);
    check_eq("wr_c1_wdata", pmem_wdata2, W1);
    c_wdata2[511:256] = W2;
    c_address2[63:32] = 32'h0000_0040;
    c_write2 = 2'b00;
    c_read2 = 2'b11;
    tick();
    c_read2 = 2'b00;
    check_eq("wr_c2_wdata", pmem_wdata2, W1);
    check_eq("wr_c2_addr", pmem_address2, 32'h8000_0020);
    wait_resp2(r2); check_eq("wr_resp", r2, 2'b10);
    check_eq("wr_c3_wdata", pmem_wdata2, W1);
    tick();

    // Read and write together on port 0 -> write
    c_address2[31:0] = 32'h0000_2000;
    c_wdata2[255:0] = W3;
    c_read2 = 2'b01;
    c_write2 = 2'b01;
    tick();
    c_read2 = 2'b00;
    c_write2 = 2'b00;
    check_eq("rw_write", pmem_write2, 1);
    check_eq("rw_read", pmem_read2, 0);
    check_eq("rw_wdata", pmem_wdata2, W3);
    wait_resp2(r2); check_eq("rw_resp", r2, 2'b01);
    tick();

    // Reset mid-BUSY, then a stray pmem_resp in IDLE
    auto2 = 1'b0;
    c_address2[31:0] = 32'h0000_3000;
    c_read2 = 2'b01;
    tick();
    c_read2 = 2'b00;
    check_eq("abort_busy_read", pmem_read2, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_async_read", pmem_read2, 0);
    check_eq("abort_async_addr", pmem_address2, 0);
    tick();
    rst = 1'b0;
    force_resp2 = 1'b1;
    #1;
    check_eq("abort_stray_resp", c_resp2, 0);
    tick();
    force_resp2 = 1'b0;
    check_eq("abort_after_read", pmem_read2, 0);
    check_eq("abort_after_resp", c_resp2, 0);
    auto2 = 1'b1;

    // Counters: 5 port-0 reads, then one contended port-1 transaction
    pulse_rst();
    for (int n = 0; n < 5; n++) begin
      c_read2 = 2'b01;
      tick();
      c_read2 = 2'b00;
      wait_resp2(r2);
      check_eq("cnt_rd_resp", r2, 2'b01);
      tick();
    end
    c_read2 = 2'b11;
    wait_resp2(r2);
    check_eq("cnt_cont_resp", r2, 2'b10);
    tick();
    c_read2 = 2'b00;
    tick();
`ifdef PMEM_ARB_PERF_CNT_EN
    exp_g0 = 32'd5; exp_g1 = 32'd1; exp_st = 32'd3;
`else
    exp_g0 = 32'd0; exp_g1 = 32'd0; exp_st = 32'd0;
`endif
    check_eq("cnt_grant0", grant_cnt2[31:0], exp_g0);
    check_eq("cnt_grant1", grant_cnt2[63:32], exp_g1);
    check_eq("cnt_stall", stall_cnt2, exp_st);

    // 4-port round robin, all ports requesting
    pulse_rst();
    c_read4 = 4'b1111;
    wait_resp4(r4); check_eq("rr4_g0", r4, 4'b0001); tick();
    wait_resp4(r4); check_eq("rr4_g1", r4, 4'b0010); tick();
    wait_resp4(r4); check_eq("rr4_g2", r4, 4'b0100); tick();
    wait_resp4(r4); check_eq("rr4_g3", r4, 4'b1000); tick();
    wait_resp4(r4); check_eq("rr4_g4", r4, 4'b0001); tick();
    c_read4 = 4'b0000;
    tick();
    check_eq("rr4_idle_read", pmem_read4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
